// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add multiplier for the execute stage.
// A request accepted at edge k updates hi/lo at edge k+32 and raises done
// for the following cycle; busy is high for the 32 iterating cycles.
//
// Build option: define MULT_SIGNED_EN for two's-complement operands (MULT);
// without it operands are unsigned (MULTU). Latency is the same in both.
//
// Ports:
//   clk      in   clock, all state updates on rising edge
//   rst      in   synchronous active-high reset
//   start_X  in   multiply request from execute
//   flush_X  in   pipeline flush, aborts an in-flight multiply
//   rs_X     in   multiplicand
//   rt_X     in   multiplier
//   busy     out  high while iterating (stall for decode/fetch)
//   done     out  one-cycle pulse when hi/lo hold a new product
//   hi, lo   out  upper/lower halves of the last completed product
module mult_unit #(
  parameter int unsigned DATA_32_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_X,
  input  logic                 flush_X,
  input  logic [DATA_32_W-1:0] rs_X,
  input  logic [DATA_32_W-1:0] rt_X,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_32_W-1:0] hi,
  output logic [DATA_32_W-1:0] lo
);

  localparam int unsigned PROD_W = 2 * DATA_32_W;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [PROD_W-1:0]    r_acc;
  logic [PROD_W-1:0]    r_mcand;   // multiplicand, shifted left each iteration
  logic [DATA_32_W-1:0] r_mplier;  // multiplier, shifted right each iteration
  logic                 r_busy;
  logic                 r_done;
  logic [DATA_32_W-1:0] r_hi;
  logic [DATA_32_W-1:0] r_lo;

  logic                 w_accept;
  logic [DATA_32_W-1:0] w_rs_mag;
  logic [DATA_32_W-1:0] w_rt_mag;
  logic [PROD_W-1:0]    w_sum;
  logic [PROD_W-1:0]    w_prod;
  logic                 w_last;

  // Flush always beats a start request
  assign w_accept = start_X & ~flush_X;
  assign w_last   = (r_cnt == CNT_W'(DATA_32_W - 1));

  // Partial-product accumulate for the current multiplier bit
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef MULT_SIGNED_EN
  logic r_neg;
  logic w_neg;

  // Iterate on magnitudes; the most negative value maps to itself, which is
  // its correct unsigned magnitude.
  assign w_rs_mag = rs_X[DATA_32_W-1] ? (-rs_X) : rs_X;
  assign w_rt_mag = rt_X[DATA_32_W-1] ? (-rt_X) : rt_X;
  assign w_neg    = rs_X[DATA_32_W-1] ^ rt_X[DATA_32_W-1];
  // Sign fix-up folded into the final write, no extra cycle
  assign w_prod   = r_neg ? (-w_sum) : w_sum;

  // Result sign captured alongside the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if ((r_state != S_BUSY) && w_accept) begin
      r_neg <= w_neg;
    end
  end
`else
  assign w_rs_mag = rs_X;
  assign w_rt_mag = rt_X;
  assign w_prod   = w_sum;
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state  <= S_BUSY;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= PROD_W'(w_rs_mag);
            r_mplier <= w_rt_mag;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (flush_X) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_hi    <= w_prod[PROD_W-1:DATA_32_W];
              r_lo    <= w_prod[DATA_32_W-1:0];
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed and random checks of mult_unit against a plain
// arithmetic product model. Follows MULT_SIGNED_EN like the design.
module tb_mult_unit;

  logic        clk;
  logic        rst;
  logic        start_X;
  logic        flush_X;
  logic [31:0] rs_X;
  logic [31:0] rt_X;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic [63:0] last_prod = 64'd0;

  mult_unit #(.DATA_32_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_X (start_X),
    .flush_X (flush_X),
    .rs_X    (rs_X),
    .rt_X    (rt_X),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference product from the operand interpretation of the build
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return 64'(sa * sb);
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the cycle after the accepting edge; optionally keeps start_X
  // high with changing operands while the multiply iterates.
  task automatic wait_done(input logic [63:0] exp, input string tag, input bit scramble);
    int n  = 0;
    int nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (scramble) begin
        start_X = 1'b1;
        rs_X    = $urandom;
        rt_X    = $urandom;
      end
      tick();
      n++;
    end
    start_X = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_busycyc"}, 64'(nb), 64'd32);
    chk({tag, "_done"}, {62'd0, busy, done}, 64'd1);
    chk({tag, "_prod"}, {hi, lo}, exp);
    last_prod = exp;
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
    rs_X    = a;
    rt_X    = b;
    start_X = 1'b1;
    tick();
    start_X = 1'b0;
    chk({tag, "_busy"}, {62'd0, busy, done}, 64'd2);
    wait_done(exp, tag, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit          saw_done;

    rst     = 1'b1;
    start_X = 1'b0;
    flush_X = 1'b0;
    rs_X    = 32'd0;
    rt_X    = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ctrl", {62'd0, busy, done}, 64'd0);
    chk("reset_prod", {hi, lo}, 64'd0);

    // Basic product and all-ones operands
    run_mult(32'd7, 32'd6, 64'h0000_0000_0000_002A, "m7x6");
    tick();
    chk("m7x6_idle", {62'd0, busy, done}, 64'd0);
`ifdef MULT_SIGNED_EN
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "ones");
    run_mult(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "neg3x5");
`else
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "ones");
    run_mult(32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, "neg3x5");
`endif

    // Flush in the 10th busy cycle: no done, result held
    rs_X = 32'd7; rt_X = 32'd6; start_X = 1'b1;
    tick();
    start_X = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("flush_pre", {62'd0, busy, done}, 64'd2);
    flush_X = 1'b1;
    tick();
    flush_X = 1'b0;
    chk("flush_ctrl", {62'd0, busy, done}, 64'd0);
    chk("flush_hold", {hi, lo}, last_prod);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    chk("flush_quiet", {63'd0, saw_done}, 64'd0);
    chk("flush_hold2", {hi, lo}, last_prod);
    run_mult(32'd2, 32'd3, 64'd6, "m2x3");

    // Start held through busy with changing operands, then back-to-back
    rs_X = 32'd5; rt_X = 32'd7; start_X = 1'b1;
    tick();
    wait_done(64'd35, "held", 1'b1);
    rs_X = 32'd4; rt_X = 32'd4; start_X = 1'b1;
    tick();
    start_X = 1'b0;
    chk("b2b_busy", {62'd0, busy, done}, 64'd2);
    wait_done(64'd16, "b2b", 1'b0);

    // Flush and start together in DONE, then in IDLE: flush wins
    rs_X = 32'd9; rt_X = 32'd9; start_X = 1'b1; flush_X = 1'b1;
    tick();
    chk("fs_done", {62'd0, busy, done}, 64'd0);
    tick();
    chk("fs_idle", {62'd0, busy, done}, 64'd0);
    start_X = 1'b0; flush_X = 1'b0;
    chk("fs_hold", {hi, lo}, last_prod);

    // Reset in the 5th busy cycle discards the multiply
    rs_X = 32'd123; rt_X = 32'd456; start_X = 1'b1;
    tick();
    start_X = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstb_ctrl", {62'd0, busy, done}, 64'd0);
    chk("rstb_prod", {hi, lo}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("rstb_nodone", {63'd0, saw_done}, 64'd0);
    run_mult(32'd9, 32'd9, 64'd81, "after_rst");

    // Random operands, with sign-boundary values mixed in
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 6 == 0) a = 32'h8000_0000;
      if (i % 8 == 1) b = 32'h7FFF_FFFF;
      if (i % 5 == 2) b = 32'd0;
      run_mult(a, b, model(a, b), "rand");
      if (i % 4 == 3) begin
        for (int k = 0; k < 3; k++) tick();
        chk("rand_hold", {hi, lo}, last_prod);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
